// File: rtl/tanimoto_ctrl.sv
// Run-level sequencer for tanimoto_top: threshold BRAM load, bounded source streaming, drain/done.
// Optional TANIMOTO_CTRL_PERF_EN adds run/stall cycle counters.
`timescale 1ns/1ps
module tanimoto_ctrl #(
    parameter int unsigned BUS_WIDTH      = 512,
    parameter int unsigned VECTOR_WIDTH   = 920,
    parameter int unsigned CNT_WIDTH      = $clog2(VECTOR_WIDTH),
    parameter int unsigned WORD_CNT_WIDTH = 32,
    parameter int unsigned DRAIN_IDLE     = 64
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_Start,
    input  logic [WORD_CNT_WIDTH-1:0] i_NumWords,
    input  logic                      i_Thr_Valid,
    input  logic [CNT_WIDTH:0]        i_Thr_Data,
    output logic                      o_Thr_Ready,
    output logic [CNT_WIDTH-1:0]      o_BRAM_Addr,
    output logic [CNT_WIDTH:0]        o_BRAM_Din,
    output logic                      o_BRAM_En,
    output logic                      o_BRAM_WrEn,
    input  logic                      i_Src_Empty,
    output logic                      o_Src_Read,
    output logic                      o_Dp_Valid,
    input  logic                      i_Dp_Read,
    input  logic                      i_IDPair_Ready,
    input  logic                      i_IDPair_Read,
    output logic                      o_Busy,
    output logic                      o_Done,
    output logic [31:0]               o_PairCount
`ifdef TANIMOTO_CTRL_PERF_EN
    ,
    output logic [31:0]               o_RunCycles,
    output logic [31:0]               o_StallCycles
`endif
);

    if (BUS_WIDTH == 0 || BUS_WIDTH % 8 != 0) begin : g_bus_width_check
        $error("tanimoto_ctrl: BUS_WIDTH must be a non-zero multiple of 8");
    end

    localparam int unsigned IdleW = $clog2(DRAIN_IDLE + 1);
    localparam logic [CNT_WIDTH:0] LastBeat  = (CNT_WIDTH + 1)'(VECTOR_WIDTH);
    localparam logic [IdleW-1:0]   IdleLimit = IdleW'(DRAIN_IDLE);

    typedef enum logic [2:0] {StIdle, StLoadThr, StStream, StDrain, StDone} state_e;

    state_e                    state_q, state_d;
    logic                      start_q;
    // One bit wider than the address so the last-entry compare survives address wrap.
    logic [CNT_WIDTH:0]        beat_q, beat_d;
    logic [WORD_CNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [IdleW-1:0]          idle_q, idle_d;
    logic [31:0]               pair_cnt_q, pair_cnt_d;
    logic                      bram_we_q, bram_we_d;
    logic [CNT_WIDTH-1:0]      bram_addr_q, bram_addr_d;
    logic [CNT_WIDTH:0]        bram_din_q, bram_din_d;

    logic start_rise;
    logic pair_xfer;

    assign start_rise = i_Start & ~start_q;
    assign pair_xfer  = i_IDPair_Ready & i_IDPair_Read;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        remaining_d = remaining_q;
        idle_d      = idle_q;
        pair_cnt_d  = pair_cnt_q;
        bram_we_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        o_Thr_Ready = 1'b0;
        o_Dp_Valid  = 1'b0;
        o_Src_Read  = 1'b0;
        o_Busy      = 1'b0;
        o_Done      = 1'b0;

        if ((state_q == StStream || state_q == StDrain) && pair_xfer && pair_cnt_q != '1) begin
            pair_cnt_d = pair_cnt_q + 32'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    state_d     = StLoadThr;
                    remaining_d = i_NumWords;
                    pair_cnt_d  = '0;
                    beat_d      = '0;
                end
            end
            StLoadThr: begin
                o_Busy      = 1'b1;
                o_Thr_Ready = 1'b1;
                if (i_Thr_Valid) begin
                    bram_we_d   = 1'b1;
                    bram_addr_d = beat_q[CNT_WIDTH-1:0];
                    bram_din_d  = i_Thr_Data;
                    beat_d      = beat_q + 1'b1;
                    if (beat_q == LastBeat) begin
                        state_d = StStream;
                    end
                end
            end
            StStream: begin
                o_Busy     = 1'b1;
                o_Dp_Valid = ~i_Src_Empty & (remaining_q != '0);
                o_Src_Read = i_Dp_Read & o_Dp_Valid;
                if (remaining_q == '0) begin
                    state_d = StDrain;
                    idle_d  = '0;
                end else if (o_Src_Read) begin
                    remaining_d = remaining_q - 1'b1;
                end
            end
            StDrain: begin
                o_Busy = 1'b1;
                if (pair_xfer) begin
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                    if (idle_d == IdleLimit) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                o_Done = 1'b1;
                if (!i_Start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            start_q     <= 1'b0;
            beat_q      <= '0;
            remaining_q <= '0;
            idle_q      <= '0;
            pair_cnt_q  <= '0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= i_Start;
            beat_q      <= beat_d;
            remaining_q <= remaining_d;
            idle_q      <= idle_d;
            pair_cnt_q  <= pair_cnt_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
        end
    end

    // The datapath reads thresholds throughout streaming, so enable stays up there.
    assign o_BRAM_En   = bram_we_q | (state_q == StStream);
    assign o_BRAM_WrEn = bram_we_q;
    assign o_BRAM_Addr = bram_addr_q;
    assign o_BRAM_Din  = bram_din_q;
    assign o_PairCount = pair_cnt_q;

`ifdef TANIMOTO_CTRL_PERF_EN
    logic [31:0] run_cyc_q, run_cyc_d;
    logic [31:0] stall_cyc_q, stall_cyc_d;

    always_comb begin
        run_cyc_d   = run_cyc_q;
        stall_cyc_d = stall_cyc_q;
        if (state_q == StIdle && start_rise) begin
            run_cyc_d   = '0;
            stall_cyc_d = '0;
        end else begin
            if ((state_q == StStream || state_q == StDrain) && run_cyc_q != '1) begin
                run_cyc_d = run_cyc_q + 32'd1;
            end
            if (state_q == StStream && remaining_q != '0 && !o_Src_Read && stall_cyc_q != '1) begin
                stall_cyc_d = stall_cyc_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_cyc_q   <= '0;
            stall_cyc_q <= '0;
        end else begin
            run_cyc_q   <= run_cyc_d;
            stall_cyc_q <= stall_cyc_d;
        end
    end

    assign o_RunCycles   = run_cyc_q;
    assign o_StallCycles = stall_cyc_q;
`endif

endmodule

// File: doc/tanimoto_ctrl.md
Name: tanimoto_ctrl

Overview:
- Run-level sequencer in front of tanimoto_top.
- Phase 1: loads the popcount-threshold BRAM from a config stream.
- Phase 2: gates a programmed number of bus words from the source FIFO into the datapath.
- Phase 3: watches the ID-pair output until it goes quiet, then counts delivered pairs and reports done.

Parameters:
- BUS_WIDTH, 512, vector bus width in bits.
- VECTOR_WIDTH, 920, fingerprint width in bits.
- CNT_WIDTH, $clog2(VECTOR_WIDTH), threshold BRAM address width; threshold data is CNT_WIDTH+1 bits.
- WORD_CNT_WIDTH, 32, width of the run word counter.
- DRAIN_IDLE, 64, consecutive cycles with no ID-pair transfer that end a run.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- i_Start  in  1  rising edge in IDLE starts a run
- i_NumWords  in  WORD_CNT_WIDTH  bus words to stream; sampled at start
- i_Thr_Valid  in  1  config stream valid
- i_Thr_Data  in  CNT_WIDTH+1  threshold value
- o_Thr_Ready  out  1  config stream ready
- o_BRAM_Addr  out  CNT_WIDTH  to tanimoto_top i_BRAM_Addr
- o_BRAM_Din  out  CNT_WIDTH+1  to i_BRAM_Din
- o_BRAM_En  out  1  to i_BRAM_En
- o_BRAM_WrEn  out  1  to i_BRAM_WrEn
- i_Src_Empty  in  1  source FIFO empty
- o_Src_Read  out  1  source FIFO read
- o_Dp_Valid  out  1  to tanimoto_top i_Valid
- i_Dp_Read  in  1  from tanimoto_top o_Read
- i_IDPair_Ready  in  1  datapath pair available
- i_IDPair_Read  in  1  consumer read of pair
- o_Busy  out  1  run in progress
- o_Done  out  1  run complete
- o_PairCount  out  32  ID pairs transferred in the current/last run

Behaviour:
- Reset (rstn=0, async): state IDLE; all outputs 0, including o_BRAM_Addr, o_PairCount and the counters.
- States: IDLE, LOAD_THR, STREAM, DRAIN, DONE.
- IDLE:
  - i_Start rising edge (registered edge detect) -> LOAD_THR.
  - Same edge: latch i_NumWords, clear o_PairCount, clear addr counter.
  - o_Busy=1 from LOAD_THR through DRAIN.
- LOAD_THR:
  - o_Thr_Ready=1.
  - Each i_Thr_Valid&o_Thr_Ready cycle registers one BRAM write at the next edge: o_BRAM_WrEn=1, o_BRAM_En=1, o_BRAM_Addr=addr, o_BRAM_Din=i_Thr_Data (1-cycle latency). Addr then increments.
  - After the write to addr VECTOR_WIDTH (VECTOR_WIDTH+1 entries, popcount 0..VECTOR_WIDTH): o_Thr_Ready drops in the same cycle as that handshake, then -> STREAM.
  - Extra config beats are not accepted.
  - If VECTOR_WIDTH+1 > 2^CNT_WIDTH, the address wraps to 0. This is a config error and is not guarded.
- STREAM:
  - o_Dp_Valid = ~i_Src_Empty & (remaining!=0).
  - o_Src_Read = i_Dp_Read & o_Dp_Valid (combinational).
  - Each o_Src_Read decrements remaining.
  - remaining==0 -> DRAIN next cycle. With i_NumWords=0, STREAM lasts exactly one cycle.
  - o_BRAM_En stays 1 (datapath reads thresholds); o_BRAM_WrEn=0.
- DRAIN:
  - Idle counter resets on every i_IDPair_Ready&i_IDPair_Read and increments otherwise.
  - Reaching DRAIN_IDLE -> DONE.
- Pair counting: o_PairCount increments on every i_IDPair_Ready&i_IDPair_Read in STREAM or DRAIN. It saturates at 2^32-1.
- DONE:
  - o_Done=1, o_Busy=0.
  - Returns to IDLE when i_Start is low; o_Done clears on that transition.
  - o_PairCount holds until the next start.
- Start is ignored while not in IDLE.
- Async reset mid-run aborts to IDLE immediately. Partial BRAM contents are left as written.

Optional Feature:
- Macro TANIMOTO_CTRL_PERF_EN.
- When defined, adds outputs o_RunCycles[31:0] and o_StallCycles[31:0]:
  - o_RunCycles counts cycles in STREAM+DRAIN.
  - o_StallCycles counts STREAM cycles with remaining!=0 and no o_Src_Read.
  - Both cleared on start, saturating, held in DONE.
- When undefined, these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset mid-STREAM (rstn low for 1 ns between edges) -> state IDLE, o_Busy=0, o_Dp_Valid=0 immediately, without waiting for a clk edge.
- Start, 921 thresholds value=i+1 with continuous valid:
  - -> 921 writes, addr 0..920, Din 1..921, one per cycle, each one cycle after its handshake.
  - o_Thr_Ready low after the 921st beat; beat 922 not consumed.
- Thresholds gapped (valid every 3rd cycle) -> same BRAM contents, no duplicate writes.
- i_NumWords=4, FIFO non-empty, i_Dp_Read toggling 1,0,1,0 -> exactly 4 o_Src_Read pulses, then o_Dp_Valid=0 with FIFO still non-empty.
- i_NumWords=0 -> STREAM one cycle, zero reads, DONE after DRAIN_IDLE=64 idle cycles.
- In DRAIN, 3 pair transfers spaced 50 cycles apart -> o_PairCount=3; DONE 64 cycles after the last one; o_Done clears one cycle after i_Start falls.
